// File: rtl/recv_reg_pkg.sv
// Shared types and sizes for the serial-to-AXIS receiver.
// Optional feature macro: RECV_REG_GLITCH_FILTER_EN (see sync_edge_det).
package recv_reg_pkg;

    localparam int WORD_BITS = 32;
    localparam int CNT_W     = 6;
    localparam int TO_W      = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/recv_reg_axis_sync_edge_det.sv
// Synchronizes the serial clock/data pair into axis_aclk and produces a
// one-cycle rising-edge strobe with the data bit aligned to it.
// With RECV_REG_GLITCH_FILTER_EN defined, an edge needs FILTER_LEN stable
// high cycles after at least FILTER_LEN stable low cycles.
module sync_edge_det #(
    parameter int FILTER_LEN = 3
) (
    input  logic axis_aclk,
    input  logic axis_reset_n,
    input  logic i_clk,
    input  logic i_data,
    output logic edge_p,
    output logic bit_q
);

    logic clk_s1, clk_s2;
    logic data_s1, data_s2;

    // Two-flop synchronizers; the clock chain resets high so a line already high at release is not an edge
    always_ff @(posedge axis_aclk) begin
        if (!axis_reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            clk_s1  <= i_clk;
            clk_s2  <= clk_s1;
            data_s1 <= i_data;
            data_s2 <= data_s1;
        end
    end

    assign bit_q = data_s2;

`ifdef RECV_REG_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] hi_run;
    logic [FW-1:0] lo_run;
    logic          armed;

    // Run-length counters on the synchronized clock; armed means the preceding low run was long enough
    always_ff @(posedge axis_aclk) begin
        if (!axis_reset_n) begin
            hi_run <= '0;
            lo_run <= '0;
            armed  <= 1'b0;
        end else if (clk_s2) begin
            lo_run <= '0;
            if (hi_run != FW'(FILTER_LEN))
                hi_run <= hi_run + 1'b1;
            if (edge_p)
                armed <= 1'b0;
        end else begin
            hi_run <= '0;
            if (lo_run != FW'(FILTER_LEN))
                lo_run <= lo_run + 1'b1;
            armed <= (lo_run >= FW'(FILTER_LEN - 1));
        end
    end

    assign edge_p = clk_s2 & armed & (hi_run == FW'(FILTER_LEN - 1));
`else
    logic clk_s3;

    // Previous synchronized clock level for plain edge detection
    always_ff @(posedge axis_aclk) begin
        if (!axis_reset_n)
            clk_s3 <= 1'b1;
        else
            clk_s3 <= clk_s2;
    end

    assign edge_p = clk_s2 & ~clk_s3;
`endif

endmodule

// File: rtl/recv_reg_axis.sv
// Serial clock/data receiver: assembles 32-bit MSB-first words and hands
// them out through a single-entry AXI-Stream master holding register.
// Optional feature macro: RECV_REG_GLITCH_FILTER_EN (glitch filter on i_clk).
module recv_reg_axis
    import recv_reg_pkg::*;
#(
    parameter int CLK_DIV    = 76,
    parameter int TIMEOUT    = CLK_DIV * 4,
    parameter int FILTER_LEN = 3
) (
    input  logic                 axis_aclk,
    input  logic                 axis_reset_n,
    input  logic                 i_clk,
    input  logic                 i_data,
    output logic [WORD_BITS-1:0] m_axis_data,
    output logic                 m_axis_valid,
    input  logic                 m_axis_ready,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic                 o_frame_err
);

    logic                 edge_p;
    logic                 bit_q;
    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [WORD_BITS-1:0] shift_reg;
    logic [WORD_BITS-1:0] next_word;
    logic                 word_done;

    sync_edge_det #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync (
        .axis_aclk    (axis_aclk),
        .axis_reset_n (axis_reset_n),
        .i_clk        (i_clk),
        .i_data       (i_data),
        .edge_p       (edge_p),
        .bit_q        (bit_q)
    );

    assign next_word = {shift_reg[WORD_BITS-2:0], bit_q};
    assign word_done = (state == SHIFT) && edge_p && (bit_cnt == CNT_W'(WORD_BITS - 1));

    // Receive FSM, idle timeout and the AXIS holding register, all registered together
    always_ff @(posedge axis_aclk) begin
        if (!axis_reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            shift_reg    <= '0;
            m_axis_data  <= '0;
            m_axis_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_overflow   <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    if (edge_p) begin
                        shift_reg <= next_word;
                        bit_cnt   <= CNT_W'(1);
                        state     <= SHIFT;
                        o_busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (edge_p) begin
                        shift_reg <= next_word;
                        to_cnt    <= '0;
                        if (word_done) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        to_cnt      <= '0;
                        bit_cnt     <= '0;
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_frame_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase

            if (word_done) begin
                if (!m_axis_valid || m_axis_ready) begin
                    m_axis_data  <= next_word;
                    m_axis_valid <= 1'b1;
                end else begin
                    o_overflow <= 1'b1;
                end
            end else if (m_axis_valid && m_axis_ready) begin
                m_axis_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_recv_reg_axis.sv
// Self-checking bench for recv_reg_axis: table-driven words plus hand-written
// overflow, timeout, reset, random-ready and glitch sequences.
module tb_recv_reg_axis;

    localparam int CLK_DIV    = 76;
    localparam int TIMEOUT    = CLK_DIV * 4;
    localparam int FILTER_LEN = 3;
    localparam int HALF       = (CLK_DIV + 2) / 2;
`ifdef RECV_REG_GLITCH_FILTER_EN
    localparam int LAT = 2 + FILTER_LEN - 1;
    localparam logic [31:0] GLITCH_EXP = 32'hF0F0F0F0;
`else
    localparam int LAT = 2;
    localparam logic [31:0] GLITCH_EXP = 32'hF0F87878;
`endif

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_data;
    } vec_t;

    logic        axis_aclk    = 1'b0;
    logic        axis_reset_n = 1'b0;
    logic        i_clk        = 1'b0;
    logic        i_data       = 1'b0;
    logic [31:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b1;
    logic        o_busy;
    logic        o_overflow;
    logic        o_frame_err;

    logic        ready_set = 1'b1;
    logic        rand_en   = 1'b0;

    int          cyc = 0;
    int          beat_cnt = 0;
    int          ov_cnt = 0;
    int          fe_cnt = 0;
    int          fe_cyc = 0;
    int          stab_err = 0;
    logic [31:0] last_beat = '0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    int          last_shift_cyc = 0;
    int          total_checks = 0;
    int          passed_checks = 0;

    vec_t        vecs [4];

    recv_reg_axis #(
        .CLK_DIV    (CLK_DIV),
        .TIMEOUT    (TIMEOUT),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .axis_aclk    (axis_aclk),
        .axis_reset_n (axis_reset_n),
        .i_clk        (i_clk),
        .i_data       (i_data),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_frame_err  (o_frame_err)
    );

    // Free-running bench clock
    always #5 axis_aclk = ~axis_aclk;

    // Cycle counter: value equals the number of rising edges seen so far
    always @(posedge axis_aclk) cyc <= cyc + 1;

    // Ready driver: fixed level or random per cycle
    always @(posedge axis_aclk) begin
        #1;
        if (rand_en)
            m_axis_ready = 1'($urandom_range(0, 1));
        else
            m_axis_ready = ready_set;
    end

    // Monitor on the falling edge: beats, pulses and AXIS stability while stalled
    always @(negedge axis_aclk) begin
        if (axis_reset_n) begin
            if (prev_hold && (!m_axis_valid || m_axis_data != prev_data))
                stab_err <= stab_err + 1;
            if (m_axis_valid && m_axis_ready) begin
                beat_cnt  <= beat_cnt + 1;
                last_beat <= m_axis_data;
            end
            if (o_overflow)
                ov_cnt <= ov_cnt + 1;
            if (o_frame_err) begin
                fe_cnt <= fe_cnt + 1;
                fe_cyc <= cyc;
            end
            prev_hold <= m_axis_valid && !m_axis_ready;
            prev_data <= m_axis_data;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge axis_aclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected)
            passed_checks++;
        else
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    endtask

    task automatic sendBit(input logic b);
        i_clk  = 1'b0;
        i_data = b;
        tick(HALF);
        i_clk = 1'b1;
        last_shift_cyc = cyc + 1 + LAT;
        tick(HALF);
    endtask

    task automatic sendBits(input logic [31:0] w, input int first, input int count);
        for (int i = first; i < first + count; i++)
            sendBit(w[31 - i]);
    endtask

    // Sends a full word and checks the valid latency against edge A of bit 32
    task automatic applyStimulus(input vec_t v);
        int b0;
        b0 = beat_cnt;
        sendBits(v.word, 0, 31);
        i_clk  = 1'b0;
        i_data = v.word[0];
        tick(HALF);
        i_clk = 1'b1;
        last_shift_cyc = cyc + 1 + LAT;
        tick(LAT);
        checkOutput("valid_before_latency", 32'(m_axis_valid), 32'd0);
        tick(1);
        checkOutput("valid_at_latency", 32'(m_axis_valid), 32'd1);
        checkOutput("data_at_latency", m_axis_data, v.exp_data);
        tick(HALF - LAT - 1);
        checkOutput("valid_after_beat", 32'(m_axis_valid), 32'd0);
        checkOutput("beat_count", 32'(beat_cnt - b0), 32'd1);
    endtask

    initial begin
        int b0;
        int o0;
        int f0;

        vecs[0] = '{word: 32'hA5A50F3C, exp_data: 32'hA5A50F3C};
        vecs[1] = '{word: 32'hFFFFFFFF, exp_data: 32'hFFFFFFFF};
        vecs[2] = '{word: 32'h00000000, exp_data: 32'h00000000};
        vecs[3] = '{word: 32'h0F0F5A3C, exp_data: 32'h0F0F5A3C};

        // Reset state
        tick(5);
        checkOutput("reset_valid", 32'(m_axis_valid), 32'd0);
        checkOutput("reset_data", m_axis_data, 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_overflow", 32'(o_overflow), 32'd0);
        checkOutput("reset_frame_err", 32'(o_frame_err), 32'd0);
        axis_reset_n = 1'b1;
        tick(10);

        // Table of plain words with ready high
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            tick(10);
        end

        // Partial word times out, then a clean word
        b0 = beat_cnt;
        f0 = fe_cnt;
        sendBits(32'hABC00000, 0, 12);
        checkOutput("busy_partial", 32'(o_busy), 32'd1);
        i_clk = 1'b0;
        tick(TIMEOUT + 40);
        checkOutput("frame_err_count", 32'(fe_cnt - f0), 32'd1);
        checkOutput("frame_err_timing", 32'(fe_cyc - last_shift_cyc), 32'(TIMEOUT));
        checkOutput("busy_after_timeout", 32'(o_busy), 32'd0);
        checkOutput("no_beat_on_timeout", 32'(beat_cnt - b0), 32'd0);
        applyStimulus('{word: 32'h0000FFFF, exp_data: 32'h0000FFFF});
        tick(10);

        // Overflow: second word arrives while the first is still held
        ready_set = 1'b0;
        tick(3);
        b0 = beat_cnt;
        o0 = ov_cnt;
        sendBits(32'h12345678, 0, 32);
        checkOutput("ovf_first_valid", 32'(m_axis_valid), 32'd1);
        checkOutput("ovf_first_data", m_axis_data, 32'h12345678);
        sendBits(32'hDEADBEEF, 0, 32);
        tick(5);
        checkOutput("ovf_pulse_count", 32'(ov_cnt - o0), 32'd1);
        checkOutput("ovf_held_data", m_axis_data, 32'h12345678);
        checkOutput("ovf_no_beat_yet", 32'(beat_cnt - b0), 32'd0);
        ready_set = 1'b1;
        tick(4);
        checkOutput("ovf_beat_count", 32'(beat_cnt - b0), 32'd1);
        checkOutput("ovf_beat_data", last_beat, 32'h12345678);
        checkOutput("ovf_valid_drop", 32'(m_axis_valid), 32'd0);
        tick(100);
        checkOutput("ovf_no_second_beat", 32'(beat_cnt - b0), 32'd1);

        // Reset in the middle of bit 16 with i_clk held high through release
        sendBits(32'h5555AAAA, 0, 15);
        i_clk  = 1'b0;
        i_data = 1'b1;
        tick(HALF);
        i_clk = 1'b1;
        tick(10);
        checkOutput("busy_before_reset", 32'(o_busy), 32'd1);
        axis_reset_n = 1'b0;
        tick(4);
        axis_reset_n = 1'b1;
        tick(1);
        checkOutput("rst_valid", 32'(m_axis_valid), 32'd0);
        checkOutput("rst_data", m_axis_data, 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        tick(20);
        checkOutput("rst_no_spurious_shift", 32'(o_busy), 32'd0);
        i_clk = 1'b0;
        tick(10);
        applyStimulus('{word: 32'h80000001, exp_data: 32'h80000001});
        tick(10);

        // Random ready while a word is pending
        b0 = beat_cnt;
        rand_en = 1'b1;
        sendBits(32'hC3C35A5A, 0, 32);
        for (int i = 0; i < 300 && beat_cnt == b0; i++)
            tick(1);
        rand_en   = 1'b0;
        ready_set = 1'b1;
        tick(5);
        checkOutput("rand_beat_count", 32'(beat_cnt - b0), 32'd1);
        checkOutput("rand_beat_data", last_beat, 32'hC3C35A5A);
        checkOutput("axis_stable", 32'(stab_err), 32'd0);

        // One-cycle glitch on i_clk after bit 10
        b0 = beat_cnt;
        sendBits(32'hF0F0F0F0, 0, 10);
        i_clk  = 1'b0;
        i_data = 1'b1;
        tick(20);
        i_clk = 1'b1;
        tick(1);
        i_clk = 1'b0;
        tick(20);
        sendBits(32'hF0F0F0F0, 10, 22);
        i_clk = 1'b0;
        tick(TIMEOUT + 40);
        checkOutput("glitch_beat_count", 32'(beat_cnt - b0), 32'd1);
        checkOutput("glitch_word", last_beat, GLITCH_EXP);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
